// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter granting two requesters access to one shared
// sequential multiplier. Start/stop handshake: one mul_start strobe launches the
// multiplier, a second strobe (in the done cycle) returns it from stopped to idle.
// Optional macro ARB_TIMEOUT_EN: bounded wait on mul_ready with a sticky err flag.
module mult_arbiter #(
    parameter int unsigned N              = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic           clock,
    input  logic           rst,
    input  logic           req0,
    input  logic           req1,
    input  logic [N-1:0]   a0,
    input  logic [N-1:0]   b0,
    input  logic [N-1:0]   a1,
    input  logic [N-1:0]   b1,
    output logic           gnt0,
    output logic           gnt1,
    output logic           done0,
    output logic           done1,
    output logic [2*N-1:0] product,
    output logic           mul_start,
    output logic [N-1:0]   mul_a,
    output logic [N-1:0]   mul_b,
    input  logic           mul_ready,
    input  logic [2*N-1:0] mul_product,
    output logic           err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_CLEAR = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             prio_q, prio_d;      // requester favoured when both request
    logic             sel_q, sel_d;        // requester currently being served
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic             start_q, start_d;
    logic [N-1:0]     mul_a_q, mul_a_d;
    logic [N-1:0]     mul_b_q, mul_b_d;
    logic [2*N-1:0]   product_q, product_d;
    logic             pick_c;
    logic             finish_c;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    // State and output registers; synchronous reset favours requester 0.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q   <= S_IDLE;
            prio_q    <= 1'b0;
            sel_q     <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            start_q   <= 1'b0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            product_q <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            sel_q     <= sel_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            start_q   <= start_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            product_q <= product_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    // Next-state and next-output logic; strobes default low, everything else holds.
    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        sel_d     = sel_q;
        gnt0_d    = gnt0_q;
        gnt1_d    = gnt1_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        start_d   = 1'b0;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        product_d = product_q;
        pick_c    = 1'b0;
        finish_c  = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    pick_c  = (req0 && req1) ? prio_q : req1;
                    sel_d   = pick_c;
                    gnt0_d  = !pick_c;
                    gnt1_d  = pick_c;
                    mul_a_d = pick_c ? a1 : a0;
                    mul_b_d = pick_c ? b1 : b0;
                    start_d = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT;
`ifdef ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (mul_ready) begin
                    product_d = mul_product;
                    finish_c  = 1'b1;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    product_d = '0;
                    err_d     = 1'b1;
                    finish_c  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
                if (finish_c) begin
                    state_d = S_CLEAR;
                    start_d = 1'b1;
                    done0_d = !sel_q;
                    done1_d = sel_q;
                end
            end
            S_CLEAR: begin
                prio_d  = !sel_q;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign mul_start = start_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign product   = product_q;
`ifdef ARB_TIMEOUT_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: behavioural multiplier model, queue-driven requesters,
// and a round-robin service-order model. ARB_TIMEOUT_EN enables the timeout test.
`timescale 1ns/1ps
module tb_mult_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned PW = 2 * N;
    localparam int unsigned TO = 64;

    logic          clock = 1'b0;
    logic          rst   = 1'b1;
    logic          req0  = 1'b0;
    logic          req1  = 1'b0;
    logic [N-1:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic          gnt0, gnt1, done0, done1, mul_start, mul_ready, err;
    logic [PW-1:0] product, mul_product;
    logic [N-1:0]  mul_a, mul_b;

    int total = 0;
    int bad   = 0;

    mult_arbiter #(.N(N), .TIMEOUT_CYCLES(TO)) dut (
        .clock       (clock),
        .rst         (rst),
        .req0        (req0),
        .req1        (req1),
        .a0          (a0),
        .b0          (b0),
        .a1          (a1),
        .b1          (b1),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .done0       (done0),
        .done1       (done1),
        .product     (product),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_ready   (mul_ready),
        .mul_product (mul_product),
        .err         (err)
    );

    always #5 clock = ~clock;

    // Multiplier model: idle -> running (latency cycles) -> stopped (ready) -> idle.
    logic [1:0]    m_st      = 2'd0;
    int            m_cnt     = 0;
    logic [PW-1:0] m_p       = '0;
    logic [PW-1:0] junk      = '0;
    logic          tie_low   = 1'b0;
    int            lat_fixed = 0;

    always @(posedge clock) begin
        junk <= PW'($urandom);
        if (rst) begin
            m_st  <= 2'd0;
            m_cnt <= 0;
            m_p   <= '0;
        end else begin
            case (m_st)
                2'd0: if (mul_start) begin
                    m_p   <= PW'(mul_a) * PW'(mul_b);
                    m_cnt <= (lat_fixed > 0) ? lat_fixed - 1 : int'($urandom_range(0, 6));
                    m_st  <= 2'd1;
                end
                2'd1: if (m_cnt == 0) m_st <= 2'd2; else m_cnt <= m_cnt - 1;
                2'd2: if (mul_start) m_st <= 2'd0;
                default: m_st <= 2'd0;
            endcase
        end
    end

    assign mul_ready   = (m_st == 2'd2) && !tie_low;
    assign mul_product = (m_st == 2'd2) ? m_p : junk;

    // Requester queues, predicted service, observed service.
    logic [N-1:0]  q0_a[$], q0_b[$], q1_a[$], q1_b[$];
    bit            exp_who[$];
    logic [PW-1:0] exp_prod[$];
    bit            obs_who[$];
    logic [PW-1:0] obs_prod[$];
    int            proto_err = 0;
    bit            err_ever  = 1'b0;
    bit            m_prio    = 1'b0;

    task automatic push_op(input bit who, input logic [N-1:0] a, input logic [N-1:0] b);
        if (who) begin q1_a.push_back(a); q1_b.push_back(b); end
        else     begin q0_a.push_back(a); q0_b.push_back(b); end
    endtask

    // Service order when both requesters keep requesting while work remains.
    task automatic predict();
        int i0 = 0;
        int i1 = 0;
        bit pick;
        exp_who.delete();
        exp_prod.delete();
        while (i0 < q0_a.size() || i1 < q1_a.size()) begin
            if (i0 < q0_a.size() && i1 < q1_a.size()) pick = m_prio;
            else pick = (i1 < q1_a.size());
            if (pick) begin exp_prod.push_back(PW'(q1_a[i1]) * PW'(q1_b[i1])); i1++; end
            else      begin exp_prod.push_back(PW'(q0_a[i0]) * PW'(q0_b[i0])); i0++; end
            exp_who.push_back(pick);
            m_prio = !pick;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clock);
        rst = 1'b0;
        m_prio = 1'b0;
    endtask

    // Drive both requesters from their queues until drained, recording done events.
    task automatic run_queues(input int budget);
        int cyc = 0;
        obs_who.delete();
        obs_prod.delete();
        proto_err = 0;
        @(negedge clock);
        if (q0_a.size() > 0) begin req0 = 1'b1; a0 = q0_a[0]; b0 = q0_b[0]; end else req0 = 1'b0;
        if (q1_a.size() > 0) begin req1 = 1'b1; a1 = q1_a[0]; b1 = q1_b[0]; end else req1 = 1'b0;
        while ((req0 || req1) && cyc < budget) begin
            @(negedge clock);
            cyc++;
            err_ever = err_ever | (err !== 1'b0);
            if ((gnt0 && gnt1) || (done0 && done1) || (done0 && !gnt0) || (done1 && !gnt1))
                proto_err++;
            if (done0 === 1'b1 && req0) begin
                obs_who.push_back(1'b0); obs_prod.push_back(product);
                void'(q0_a.pop_front()); void'(q0_b.pop_front());
                if (q0_a.size() > 0) begin a0 = q0_a[0]; b0 = q0_b[0]; end else req0 = 1'b0;
            end
            if (done1 === 1'b1 && req1) begin
                obs_who.push_back(1'b1); obs_prod.push_back(product);
                void'(q1_a.pop_front()); void'(q1_b.pop_front());
                if (q1_a.size() > 0) begin a1 = q1_a[0]; b1 = q1_b[0]; end else req1 = 1'b0;
            end
            if (!req0) begin a0 = N'($urandom); b0 = N'($urandom); end
            if (!req1) begin a1 = N'($urandom); b1 = N'($urandom); end
        end
        total++;
        if (req0 || req1) begin
            bad++;
            $display("FAIL drain: pending ops=%0d after %0d cycles, required 0",
                     q0_a.size() + q1_a.size(), cyc);
        end
        req0 = 1'b0; req1 = 1'b0;
        q0_a.delete(); q0_b.delete(); q1_a.delete(); q1_b.delete();
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset();
        @(negedge clock);
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
        a0 = N'($urandom); b0 = N'($urandom); a1 = N'($urandom); b1 = N'($urandom);
        repeat (2) @(negedge clock);
        total++;
        if ({gnt0, gnt1, done0, done1, mul_start, err} !== 6'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b, required 000000", {gnt0, gnt1, done0, done1, mul_start, err});
        end
        total++;
        if (mul_a !== '0 || mul_b !== '0) begin
            bad++; $display("FAIL reset_operands: got a=%0d b=%0d, required 0 0", mul_a, mul_b);
        end
        total++;
        if (product !== '0) begin
            bad++; $display("FAIL reset_product: got %0d, required 0", product);
        end
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; m_prio = 1'b0;
        repeat (3) @(negedge clock);
        total++;
        if ({gnt0, gnt1, mul_start} !== 3'b0) begin
            bad++; $display("FAIL idle_stays: got %b, required 000", {gnt0, gnt1, mul_start});
        end
    endtask

    // Single op 3*5, latency 10: timing of grant, both strobes, ready and done.
    task automatic test_single();
        int gstart = -1, first_start = -1, rdy = -1, dn = -1, nstart = 0;
        logic [PW-1:0] p = '0, p_pre = '1;
        bit gnt1_seen = 1'b0, gnt_gap = 1'b0;
        logic start_at_done = 1'b0, g_after = 1'b1;
        do_reset();
        lat_fixed = 10;
        @(negedge clock);
        req0 = 1'b1; a0 = 4'd3; b0 = 4'd5;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (gnt0 === 1'b1 && gstart < 0) gstart = c;
            if (gnt1 !== 1'b0) gnt1_seen = 1'b1;
            if (gstart > 0 && dn < 0 && gnt0 !== 1'b1) gnt_gap = 1'b1;
            if (dn > 0 && c == dn + 1) g_after = gnt0;
            if (mul_start === 1'b1) begin nstart++; if (first_start < 0) first_start = c; end
            if (mul_ready && rdy < 0) rdy = c;
            if (done0 === 1'b1 && dn < 0) begin
                dn = c; p = product; start_at_done = mul_start; req0 = 1'b0;
            end
            if (dn < 0) p_pre = product;
        end
        total++; if (gstart != 1) begin bad++; $display("FAIL single_gnt_cycle: got %0d, required 1", gstart); end
        total++; if (first_start != 1) begin bad++; $display("FAIL single_start_cycle: got %0d, required 1", first_start); end
        total++; if (dn != rdy + 1 || rdy != 12) begin
            bad++; $display("FAIL single_done_cycle: got ready=%0d done=%0d, required 12 13", rdy, dn);
        end
        total++; if (p !== PW'(15)) begin bad++; $display("FAIL single_product: got %0d, required 15", p); end
        total++; if (p_pre !== '0) begin bad++; $display("FAIL single_product_before: got %0d, required 0", p_pre); end
        total++; if (nstart != 2 || start_at_done !== 1'b1) begin
            bad++; $display("FAIL single_starts: got %0d strobes (done-cycle strobe %b), required 2 (1)", nstart, start_at_done);
        end
        total++; if (gnt_gap || gnt1_seen || g_after !== 1'b0) begin
            bad++; $display("FAIL single_gnt_window: got gap=%0d gnt1=%0d after=%b, required 0 0 0", gnt_gap, gnt1_seen, g_after);
        end
        total++; if (product !== PW'(15)) begin bad++; $display("FAIL single_product_hold: got %0d, required 15", product); end
        lat_fixed = 0;
    endtask

    task automatic test_both();
        do_reset();
        push_op(1'b0, 4'd2, 4'd7);
        push_op(1'b1, 4'd15, 4'd15);
        predict();
        run_queues(200);
        total++; if (obs_who.size() != 2) begin bad++; $display("FAIL both_count: got %0d, required 2", obs_who.size()); end
        if (obs_who.size() >= 2) begin
            total++; if (obs_who[0] !== 1'b0 || obs_prod[0] !== PW'(14)) begin
                bad++; $display("FAIL both_first: got who=%0d prod=%0d, required 0 14", obs_who[0], obs_prod[0]);
            end
            total++; if (obs_who[1] !== 1'b1 || obs_prod[1] !== PW'(225)) begin
                bad++; $display("FAIL both_second: got who=%0d prod=%0d, required 1 225", obs_who[1], obs_prod[1]);
            end
        end
        total++; if (proto_err != 0) begin bad++; $display("FAIL both_exclusive: got %0d violations, required 0", proto_err); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            push_op(1'b0, N'($urandom), N'($urandom));
            push_op(1'b1, N'($urandom), N'($urandom));
        end
        predict();
        run_queues(300);
        total++; if (obs_who.size() != 4) begin bad++; $display("FAIL b2b_count: got %0d, required 4", obs_who.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < obs_who.size()) begin
                total++; if (obs_who[i] !== 1'(i % 2)) begin
                    bad++; $display("FAIL b2b_order[%0d]: got %0d, required %0d", i, obs_who[i], i % 2);
                end
                total++; if (obs_prod[i] !== exp_prod[i]) begin
                    bad++; $display("FAIL b2b_product[%0d]: got %0d, required %0d", i, obs_prod[i], exp_prod[i]);
                end
            end
        end
        total++; if (proto_err != 0) begin bad++; $display("FAIL b2b_exclusive: got %0d violations, required 0", proto_err); end
    endtask

    // Random queue depths, operands and latencies; pointer carries across rounds.
    task automatic test_random();
        for (int r = 0; r < 12; r++) begin
            int n0 = int'($urandom_range(0, 3));
            int n1 = int'($urandom_range(0, 3));
            if (n0 + n1 == 0) n0 = 1;
            for (int i = 0; i < n0; i++) push_op(1'b0, N'($urandom), N'($urandom));
            for (int i = 0; i < n1; i++) push_op(1'b1, N'($urandom), N'($urandom));
            predict();
            run_queues(400);
            total++; if (obs_who.size() != exp_who.size()) begin
                bad++; $display("FAIL rand_count[%0d]: got %0d, required %0d", r, obs_who.size(), exp_who.size());
            end
            for (int i = 0; i < exp_who.size(); i++) begin
                if (i < obs_who.size()) begin
                    total++; if (obs_who[i] !== exp_who[i] || obs_prod[i] !== exp_prod[i]) begin
                        bad++; $display("FAIL rand_op[%0d.%0d]: got who=%0d prod=%0d, required who=%0d prod=%0d",
                                        r, i, obs_who[i], obs_prod[i], exp_who[i], exp_prod[i]);
                    end
                end
            end
            total++; if (proto_err != 0) begin bad++; $display("FAIL rand_exclusive[%0d]: got %0d, required 0", r, proto_err); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        lat_fixed = 10;
        @(negedge clock);
        req0 = 1'b1; a0 = N'($urandom); b0 = N'($urandom);
        repeat (4) @(negedge clock);
        total++; if (gnt0 !== 1'b1 || mul_ready !== 1'b0) begin
            bad++; $display("FAIL midrst_busy: got gnt0=%b ready=%b, required 1 0", gnt0, mul_ready);
        end
        rst = 1'b1;
        @(negedge clock);
        rst = 1'b0; req0 = 1'b0; m_prio = 1'b0; lat_fixed = 0;
        total++;
        if ({gnt0, gnt1, done0, done1, mul_start, err} !== 6'b0 || mul_a !== '0 || mul_b !== '0 || product !== '0) begin
            bad++; $display("FAIL midrst_outputs: got ctrl=%b a=%0d b=%0d p=%0d, required all 0",
                            {gnt0, gnt1, done0, done1, mul_start, err}, mul_a, mul_b, product);
        end
        repeat (2) @(negedge clock);
        total++; if ({gnt0, gnt1, done0, done1, mul_start} !== 5'b0) begin
            bad++; $display("FAIL midrst_idle: got %b, required 00000", {gnt0, gnt1, done0, done1, mul_start});
        end
        push_op(1'b1, 4'd9, 4'd9);
        predict();
        run_queues(200);
        total++; if (obs_who.size() != 1) begin bad++; $display("FAIL midrst_count: got %0d, required 1", obs_who.size()); end
        if (obs_who.size() >= 1) begin
            total++; if (obs_who[0] !== 1'b1 || obs_prod[0] !== PW'(81)) begin
                bad++; $display("FAIL midrst_op: got who=%0d prod=%0d, required 1 81", obs_who[0], obs_prod[0]);
            end
        end
    endtask

    task automatic test_no_spurious_err();
        total++;
        if (err_ever || err !== 1'b0) begin
            bad++; $display("FAIL err_idle: got err seen=%0d now=%b, required 0 0", err_ever, err);
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int dn = -1;
        logic [PW-1:0] p = '1;
        logic err_pre = 1'b1, err_dn = 1'b0;
        do_reset();
        tie_low = 1'b1;
        @(negedge clock);
        req0 = 1'b1; a0 = 4'd7; b0 = 4'd9;
        for (int c = 1; c <= 90; c++) begin
            @(negedge clock);
            if (done0 === 1'b1 && dn < 0) begin dn = c; p = product; err_dn = err; req0 = 1'b0; end
            if (dn < 0) err_pre = err;
        end
        total++; if (dn != int'(TO) + 2) begin bad++; $display("FAIL to_done_cycle: got %0d, required %0d", dn, TO + 2); end
        total++; if (p !== '0) begin bad++; $display("FAIL to_product: got %0d, required 0", p); end
        total++; if (err_pre !== 1'b0 || err_dn !== 1'b1 || err !== 1'b1) begin
            bad++; $display("FAIL to_err: got before=%b at_done=%b later=%b, required 0 1 1", err_pre, err_dn, err);
        end
        tie_low = 1'b0;
        do_reset();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL to_err_reset: got %b, required 0", err); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_both();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_no_spurious_err();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter: N, default 4, operand width in bits of the shared sequential multiplier.
REQ-002 Parameter: TIMEOUT_CYCLES, default 64, maximum cycles to wait for mul_ready (used only under REQ-027).
REQ-003 Ports (name  direction  width  meaning):
- clock  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- req0, req1  in  1  level request from requester 0/1; held high until the matching done pulse.
- a0, b0, a1, b1  in  N  operands for requester 0/1.
- gnt0, gnt1  out  1  high while the requester owns the multiplier.
- done0, done1  out  1  one-cycle completion pulse.
- product  out  2N  result; valid in the done cycle.
- mul_start  out  1  start strobe to the multiplier sequencer.
- mul_a, mul_b  out  N  registered operands to the multiplier.
- mul_ready  in  1  multiplier ready (high while the multiplier is stopped).
- mul_product  in  2N  multiplier result.
- err  out  1  sticky timeout flag (REQ-027).

Function
REQ-004 The FSM SHALL have states S_IDLE, S_START, S_WAIT, S_CLEAR.
REQ-005 S_IDLE: if neither req0 nor req1 is high, the FSM SHALL stay in S_IDLE.
REQ-006 S_IDLE: if exactly one request is high, the block SHALL grant that requester.
REQ-007 S_IDLE: if both requests are high, the block SHALL grant the requester not served last (round-robin pointer).
REQ-008 On grant, the block SHALL latch that requester's a/b into mul_a/mul_b, set the matching gnt, and go to S_START.
REQ-009 S_START: mul_start SHALL be 1 for exactly this one cycle; mul_ready SHALL be ignored; next state is S_WAIT.
REQ-010 S_WAIT: the FSM SHALL remain until mul_ready=1, then capture mul_product into the product register and go to S_CLEAR.
REQ-011 S_CLEAR: mul_start SHALL be 1 for one cycle to return the multiplier from stopped to idle.
REQ-012 S_CLEAR: the granted requester's done SHALL pulse for this one cycle, and product SHALL hold the captured value.
REQ-013 S_CLEAR: the round-robin pointer SHALL record the served requester; gnt SHALL drop; next state is S_IDLE.
REQ-014 Latency: request seen in S_IDLE at cycle t; gnt from t+1 through the done cycle; mul_start at t+1; done at the cycle after mul_ready is sampled high.
REQ-015 gnt0 and gnt1 SHALL never both be high; done0 and done1 SHALL never both be high.
REQ-016 A request deasserted mid-operation SHALL NOT abort the operation; done SHALL still pulse.
REQ-017 A new grant SHALL occur no earlier than the cycle after S_CLEAR.
REQ-018 The other requester's operands SHALL be ignored while a grant is active.
REQ-019 product SHALL hold its last value outside the done cycle.
REQ-020 product SHALL be the full 2N-bit mul_product with no truncation.
REQ-021 With req held high continuously, a requester SHALL be re-granted only if the other requester is not requesting.

Reset
REQ-022 rst=1 at any clock edge, including mid-operation, SHALL force the FSM to S_IDLE.
REQ-023 rst=1 SHALL set the pointer to favour requester 0.
REQ-024 rst=1 SHALL drive gnt0, gnt1, done0, done1, mul_start and err to 0.
REQ-025 rst=1 SHALL clear mul_a, mul_b and product to 0.
REQ-026 The multiplier SHALL be reset by the system alongside the arbiter; the arbiter SHALL issue no recovery strobe.

Configuration
REQ-027 With ARB_TIMEOUT_EN defined, a counter SHALL run in S_WAIT and clear on entry. If TIMEOUT_CYCLES cycles pass without mul_ready, the FSM SHALL go to S_CLEAR with product=0, set err=1 (sticky until rst) and pulse done normally.
REQ-028 Without ARB_TIMEOUT_EN, no counter SHALL be built, S_WAIT SHALL wait indefinitely, and err SHALL be tied to 0.

Verification
REQ-029 N=4, req0 with a0=3, b0=5; multiplier model gives ready after 10 cycles -> gnt0, a single mul_start, done0 pulse with product=15, then second mul_start in the done cycle.
REQ-030 After reset, req0 and req1 rise in the same cycle (a0=2, b0=7; a1=15, b1=15) -> requester 0 served first with product=14, then requester 1 with product=225; gnt never overlaps.
REQ-031 req0 and req1 held high for 4 operations -> grant order 0,1,0,1 and one done per operation.
REQ-032 rst pulsed for one cycle during S_WAIT -> next cycle all outputs 0 and FSM in S_IDLE; a fresh req1 (a1=9, b1=9) then completes with product=81.
REQ-033 ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=64, mul_ready tied 0, req0 -> done0 after 64 wait cycles, product=0, err=1 held; err=1 without the macro is a failure.
